data_memory_access_unit: RTL and testbench

//   Load/store stage directly downstream of the data-memory address calculator.

---
 rtl/data_memory_access_unit_if.sv | 28 ++
 rtl/data_memory_access_unit.sv | 131 +++++++++++++
 tb/tb_data_memory_access_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/data_memory_access_unit_if.sv
// Request/response bus between the address calculator (master) and the
// data memory access unit (slave).
interface data_memory_access_unit_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
);
    // Handshake: a request transfers on a rising edge where valid and ready are
    // both high; valid while ready is low is dropped, not queued. done pulses
    // for one cycle per accepted request, and err/rdata are meaningful with it.
    logic                  valid;
    logic                  ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  done;
    logic                  err;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rdata, done, err
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rdata, done, err
    );
endinterface

// File: rtl/data_memory_access_unit.sv
// Load/store stage: one word access per request to an internal RAM with a
// fixed number of wait states; out-of-range addresses complete with err.
module data_memory_access_unit #(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 2048,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    data_memory_access_unit_if.slave mem_if,
    output logic [1:0]            state_o
);
    localparam int                IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [3:0]        WS_L    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q;
    logic                  ready_q;
    logic                  done_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  accept;
    logic                  in_range;
    logic                  acc_fire;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [IDX_W-1:0]      acc_idx;
    logic                  acc_we;
    logic [DATA_WIDTH-1:0] acc_wdata;

    // With no wait states the access happens on the accept edge itself, so the
    // RAM port takes the live request; otherwise it takes the latched one.
    always_comb begin
        accept    = ready_q & mem_if.valid;
        in_range  = {1'b0, mem_if.addr} < DEPTH_L;
        acc_fire  = (accept && in_range && (WAIT_STATES == 0)) ||
                    ((state_q == ST_WAIT) && (cnt_q == 4'd0));
        acc_addr  = (state_q == ST_WAIT) ? addr_q  : mem_if.addr;
        acc_we    = (state_q == ST_WAIT) ? we_q    : mem_if.we;
        acc_wdata = (state_q == ST_WAIT) ? wdata_q : mem_if.wdata;
        acc_idx   = acc_addr[IDX_W-1:0];
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (acc_fire && acc_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    if (accept) begin
                        addr_q  <= mem_if.addr;
                        we_q    <= mem_if.we;
                        wdata_q <= mem_if.wdata;
                        ready_q <= 1'b0;
                        if (!in_range) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else if (WAIT_STATES == 0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            if (!acc_we) rdata_q <= mem[acc_idx];
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WS_L - 4'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        if (!acc_we) rdata_q <= mem[acc_idx];
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_if.ready = ready_q;
    assign mem_if.done  = done_q;
    assign mem_if.err   = err_q;
    assign mem_if.rdata = rdata_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_data_memory_access_unit.sv
// Directed bench: unit A (1024 words, 2 wait states) and unit B (2048 words,
// no wait states) driven from one linear sequence of steps.
module tb_data_memory_access_unit;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a;
    logic       rst_b;
    logic [1:0] state_a;
    logic [1:0] state_b;

    data_memory_access_unit_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) a_if ();
    data_memory_access_unit_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) b_if ();

    data_memory_access_unit #(
        .ADDR_WIDTH(11), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(2)
    ) dut_a (
        .clk_i(clk), .rst_i(rst_a), .mem_if(a_if.slave), .state_o(state_a)
    );

    data_memory_access_unit #(
        .ADDR_WIDTH(11), .DATA_WIDTH(32), .MEM_DEPTH(2048), .WAIT_STATES(0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst_b), .mem_if(b_if.slave), .state_o(state_b)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] o_ready(input int sel);
        return (sel == 0) ? {31'b0, a_if.ready} : {31'b0, b_if.ready};
    endfunction
    function automatic logic [31:0] o_done(input int sel);
        return (sel == 0) ? {31'b0, a_if.done} : {31'b0, b_if.done};
    endfunction
    function automatic logic [31:0] o_err(input int sel);
        return (sel == 0) ? {31'b0, a_if.err} : {31'b0, b_if.err};
    endfunction
    function automatic logic [31:0] o_rdata(input int sel);
        return (sel == 0) ? a_if.rdata : b_if.rdata;
    endfunction
    function automatic logic [31:0] o_state(input int sel);
        return (sel == 0) ? {30'b0, state_a} : {30'b0, state_b};
    endfunction

    // ---------------- drivers ----------------
    task automatic drive(input int sel, input logic v, input logic w,
                         input logic [10:0] ad, input logic [31:0] wd);
        if (sel == 0) begin
            a_if.valid = v; a_if.we = w; a_if.addr = ad; a_if.wdata = wd;
        end else begin
            b_if.valid = v; b_if.we = w; b_if.addr = ad; b_if.wdata = wd;
        end
    endtask

    // Issue one request from idle; DONE expected lat cycles after the accept edge.
    task automatic do_req(input int sel, input logic w, input logic [10:0] ad,
                          input logic [31:0] wd, input int lat,
                          input logic exp_err, input logic [31:0] exp_rd);
        logic [31:0] e;
        check("ready_before_req", o_ready(sel), 32'd1);
        drive(sel, 1'b1, w, ad, wd);
        exp_q.push_back(exp_rd);
        @(posedge clk);
        @(negedge clk); #1;
        drive(sel, 1'b0, 1'b0, 11'd0, 32'd0);
        for (int k = 1; k <= lat; k++) begin
            if (k < lat) begin
                check("done_early", o_done(sel), 32'd0);
                @(negedge clk); #1;
            end else begin
                check("done_pulse", o_done(sel), 32'd1);
                check("err", o_err(sel), {31'b0, exp_err});
                e = exp_q.pop_front();
                check("rdata", o_rdata(sel), e);
            end
        end
        @(negedge clk); #1;
        check("done_cleared", o_done(sel), 32'd0);
        check("ready_after", o_ready(sel), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int ndone;
        drive(0, 1'b0, 1'b0, 11'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 11'd0, 32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        #12;
        check("rst_ready", o_ready(0), 32'd0);
        check("rst_done", o_done(0), 32'd0);
        check("rst_err", o_err(0), 32'd0);
        check("rst_rdata", o_rdata(0), 32'd0);
        check("rst_state", o_state(0), 32'd0);
        @(negedge clk); #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        check("ready_before_edge", o_ready(0), 32'd0);
        @(negedge clk); #1;
        check("ready_after_release_a", o_ready(0), 32'd1);
        check("ready_after_release_b", o_ready(1), 32'd1);

        // Store then load, 2 wait states
        do_req(0, 1'b1, 11'h005, 32'hDEAD_BEEF, 3, 1'b0, 32'h0);
        do_req(0, 1'b0, 11'h005, 32'h0,        3, 1'b0, 32'hDEAD_BEEF);

        // Depth boundary (1024 words)
        do_req(0, 1'b1, 11'h3FF, 32'hCAFE_F00D, 3, 1'b0, 32'hDEAD_BEEF);
        do_req(0, 1'b0, 11'h400, 32'h0,         1, 1'b1, 32'h0);
        do_req(0, 1'b0, 11'h3FF, 32'h0,         3, 1'b0, 32'hCAFE_F00D);
        do_req(0, 1'b1, 11'h7FF, 32'h1111_1111, 1, 1'b1, 32'h0);

        // Continuous valid: accepts at cycles 0,4,8,12 -> DONE at 3,7,11,15
        for (int j = 0; j < 4; j++)
            do_req(0, 1'b1, 11'(32'h20 + 4 * j), 32'hA000_0020 + 32'(4 * j), 3, 1'b0, 32'h0);
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            drive(0, (i < 13), 1'b0, 11'(32'h20 + i), 32'h0);
            if (i >= 3 && ((i - 3) % 4) == 0) begin
                check("stream_done", o_done(0), 32'd1);
                check("stream_rdata", o_rdata(0), 32'hA000_0020 + 32'(i - 3));
                ndone++;
            end else begin
                check("stream_no_done", o_done(0), 32'd0);
            end
            @(negedge clk); #1;
        end
        drive(0, 1'b0, 1'b0, 11'd0, 32'd0);
        check("stream_ready_end", o_ready(0), 32'd1);
        check("stream_done_count", 32'(ndone), 32'd4);

        // Reset during WAIT aborts the store
        do_req(0, 1'b1, 11'h010, 32'h0BAD_0001, 3, 1'b0, 32'hA000_002C);
        drive(0, 1'b1, 1'b1, 11'h010, 32'h0000_1234);
        @(posedge clk);
        @(negedge clk); #1;
        drive(0, 1'b0, 1'b0, 11'd0, 32'd0);
        check("abort_in_wait", o_state(0), 32'd1);
        rst_a = 1'b1;
        #1;
        check("abort_state_idle", o_state(0), 32'd0);
        check("abort_ready_low", o_ready(0), 32'd0);
        @(negedge clk);
        @(negedge clk); #1;
        check("abort_no_done", o_done(0), 32'd0);
        rst_a = 1'b0;
        @(negedge clk); #1;
        check("abort_no_done_after", o_done(0), 32'd0);
        do_req(0, 1'b0, 11'h010, 32'h0, 3, 1'b0, 32'h0BAD_0001);

        // Reset during DONE clears outputs immediately; RAM survives
        do_req(0, 1'b1, 11'h030, 32'h0000_0077, 3, 1'b0, 32'h0BAD_0001);
        drive(0, 1'b1, 1'b0, 11'h030, 32'h0);
        @(posedge clk);
        @(negedge clk); #1;
        drive(0, 1'b0, 1'b0, 11'd0, 32'd0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("pre_rst_done", o_done(0), 32'd1);
        check("pre_rst_rdata", o_rdata(0), 32'h0000_0077);
        rst_a = 1'b1;
        #1;
        check("async_rst_done", o_done(0), 32'd0);
        check("async_rst_err", o_err(0), 32'd0);
        check("async_rst_rdata", o_rdata(0), 32'd0);
        check("async_rst_ready", o_ready(0), 32'd0);
        @(negedge clk); #1;
        rst_a = 1'b0;
        @(negedge clk); #1;
        check("ready_after_rst", o_ready(0), 32'd1);
        do_req(0, 1'b0, 11'h030, 32'h0, 3, 1'b0, 32'h0000_0077);

        // No wait states, full 2048-word depth
        do_req(1, 1'b1, 11'h000, 32'h55AA_55AA, 1, 1'b0, 32'h0);
        do_req(1, 1'b0, 11'h000, 32'h0,         1, 1'b0, 32'h55AA_55AA);
        do_req(1, 1'b1, 11'h7FF, 32'h1234_5678, 1, 1'b0, 32'h55AA_55AA);
        do_req(1, 1'b0, 11'h7FF, 32'h0,         1, 1'b0, 32'h1234_5678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
